// File: rtl/wdt_feeder_pkg.sv
// Shared definitions for the watchdog feeder: state encoding, timer sizing
// and the legal-parameter predicate used by the top level.
package wdt_feeder_pkg;

  // FSM encoding; the numeric values are visible on the state output port.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_RUN     = 2'd2,
    ST_STARVE  = 2'd3
  } wdt_state_e;

  // Largest of three cycle counts.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Down-timer width: wide enough for the largest reload value (count - 1).
  function automatic int timer_width(input int holdoff, input int kick_period,
                                     input int hb_timeout);
    int m;
    m = max3(holdoff, kick_period, hb_timeout);
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Legal parameter ranges: a kick period of one cycle cannot toggle a pad
  // meaningfully, and the heartbeat window must cover at least one kick.
  function automatic bit params_ok(input int kick_period, input int holdoff,
                                   input int hb_timeout, input int cnt_w);
    return (kick_period >= 2) && (holdoff >= 1) &&
           (hb_timeout > kick_period) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/wdt_down_timer.sv
// Loadable down counter with a zero flag. A load always wins over a
// decrement, and a decrement at zero is ignored so the count never wraps.
module wdt_down_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload has priority, otherwise step down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, cleared by the supervisor reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wdt_feeder.sv
// Watchdog feeder: toggles the supervisor's WDI line while the application
// keeps sending heartbeat pulses, freezes it (but keeps driving it) when the
// heartbeat stops so the supervisor times out, and tri-states it when
// servicing is disabled. One kick timer paces toggles; one heartbeat timer
// measures the liveness window.
module wdt_feeder
  import wdt_feeder_pkg::*;
#(
  parameter int KICK_PERIOD = 10,
  parameter int HOLDOFF     = 20,
  parameter int HB_TIMEOUT  = 50,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hb,
  output logic             wdi,
  output logic             wdi_oe,
  output logic             starving,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] kick_cnt
);

  localparam int TMR_W = timer_width(HOLDOFF, KICK_PERIOD, HB_TIMEOUT);
  localparam bit PARAMS_OK = params_ok(KICK_PERIOD, HOLDOFF, HB_TIMEOUT, CNT_W);

  // Timers load count-1 so that a zero flag seen N cycles later fires on
  // exactly the Nth edge after the load.
  localparam logic [TMR_W-1:0] HOLDOFF_LOAD = TMR_W'(HOLDOFF - 1);
  localparam logic [TMR_W-1:0] KICK_LOAD    = TMR_W'(KICK_PERIOD - 1);
  localparam logic [TMR_W-1:0] HB_LOAD      = TMR_W'(HB_TIMEOUT - 1);

  // Registered outputs and FSM state.
  wdt_state_e       state_q, state_d;
  logic             wdi_q, wdi_d;
  logic             wdi_oe_q, wdi_oe_d;
  logic             starving_q, starving_d;
  logic [CNT_W-1:0] kick_cnt_q, kick_cnt_d;

  // Timer control.
  logic             kick_load;
  logic [TMR_W-1:0] kick_val;
  logic             kick_dec;
  logic             kick_zero;
  logic             hb_load;
  logic             hb_dec;
  logic             hb_zero;
  logic             kick_fire;

  wdt_down_timer #(
    .W (TMR_W)
  ) u_kick_tmr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (kick_load),
    .load_val_i (kick_val),
    .dec_i      (kick_dec),
    .zero_o     (kick_zero)
  );

  wdt_down_timer #(
    .W (TMR_W)
  ) u_hb_tmr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (hb_load),
    .load_val_i (HB_LOAD),
    .dec_i      (hb_dec),
    .zero_o     (hb_zero)
  );

  // Next-state, output and timer-control decisions for one clock edge.
  always_comb begin
    state_d    = state_q;
    wdi_d      = wdi_q;
    wdi_oe_d   = wdi_oe_q;
    starving_d = starving_q;
    kick_cnt_d = kick_cnt_q;
    kick_load  = 1'b0;
    kick_val   = KICK_LOAD;
    kick_dec   = 1'b0;
    hb_load    = 1'b0;
    hb_dec     = 1'b0;
    kick_fire  = 1'b0;

    if (!en) begin
      // Disable overrides everything, including a kick due this cycle.
      state_d    = ST_IDLE;
      wdi_oe_d   = 1'b0;
      wdi_d      = 1'b0;
      starving_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_HOLDOFF;
          wdi_oe_d  = 1'b1;
          kick_load = 1'b1;
          kick_val  = HOLDOFF_LOAD;
        end
        ST_HOLDOFF: begin
          // Heartbeat is not yet monitored; only the holdoff delay runs.
          if (kick_zero) begin
            state_d   = ST_RUN;
            kick_fire = 1'b1;
            kick_load = 1'b1;
            hb_load   = 1'b1;
          end else begin
            kick_dec = 1'b1;
          end
        end
        ST_RUN: begin
          if (hb) begin
            hb_load = 1'b1;
          end else begin
            hb_dec = 1'b1;
          end
          // A heartbeat arriving on the expiry cycle keeps us alive.
          if (!hb && hb_zero) begin
            state_d    = ST_STARVE;
            starving_d = 1'b1;
          end else if (kick_zero) begin
            kick_fire = 1'b1;
            kick_load = 1'b1;
          end else begin
            kick_dec = 1'b1;
          end
        end
        ST_STARVE: begin
          // wdi stays frozen and driven until the application recovers.
          if (hb) begin
            state_d    = ST_RUN;
            starving_d = 1'b0;
            kick_load  = 1'b1;
            hb_load    = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (kick_fire) begin
      wdi_d = ~wdi_q;
      if (kick_cnt_q != {CNT_W{1'b1}}) begin
        kick_cnt_d = kick_cnt_q + 1'b1;
      end
    end
  end

  // State and output registers; the supervisor reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wdi_q      <= 1'b0;
      wdi_oe_q   <= 1'b0;
      starving_q <= 1'b0;
      kick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wdi_q      <= wdi_d;
      wdi_oe_q   <= wdi_oe_d;
      starving_q <= starving_d;
      kick_cnt_q <= kick_cnt_d;
    end
  end

  assign state    = state_q;
  assign wdi      = wdi_q;
  assign wdi_oe   = wdi_oe_q;
  assign starving = starving_q;
  assign kick_cnt = kick_cnt_q;

  // Reject illegal parameter combinations in simulation.
  param_range_a : assert property (@(posedge clk) PARAMS_OK);

endmodule

// File: tb/tb_wdt_feeder.sv
// Self-checking bench for wdt_feeder. Two instances share all inputs: the
// default 16-bit counter and a 4-bit counter that must saturate at 15.
// The reference model tracks absolute deadlines (cycle of next toggle,
// cycle of heartbeat expiry) rather than down counters.
module tb_wdt_feeder;

  localparam int KP  = 10;
  localparam int HO  = 20;
  localparam int HBT = 50;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        hb    = 1'b0;

  logic        wdi, wdi_oe, starving;
  logic [1:0]  state;
  logic [15:0] kick_cnt;
  logic        wdi4, wdi_oe4, starving4;
  logic [1:0]  state4;
  logic [3:0]  kick_cnt4;

  wdt_feeder #(.KICK_PERIOD(KP), .HOLDOFF(HO), .HB_TIMEOUT(HBT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hb(hb),
    .wdi(wdi), .wdi_oe(wdi_oe), .starving(starving), .state(state), .kick_cnt(kick_cnt)
  );

  wdt_feeder #(.KICK_PERIOD(KP), .HOLDOFF(HO), .HB_TIMEOUT(HBT), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .hb(hb),
    .wdi(wdi4), .wdi_oe(wdi_oe4), .starving(starving4), .state(state4), .kick_cnt(kick_cnt4)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model
  int   m_state;
  logic m_wdi, m_oe, m_starv;
  int   m_cnt;
  int   kick_at;
  int   starve_at;

  task automatic model_reset();
    m_state = 0; m_wdi = 1'b0; m_oe = 1'b0; m_starv = 1'b0;
    m_cnt = 0; kick_at = 0; starve_at = 0;
  endtask

  task automatic model_edge(input logic e, input logic h);
    bit fire;
    fire = 1'b0;
    if (!e) begin
      m_state = 0; m_oe = 1'b0; m_wdi = 1'b0; m_starv = 1'b0;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_oe = 1'b1; kick_at = cyc + HO; end
        1: if (cyc == kick_at) begin m_state = 2; fire = 1'b1; starve_at = cyc + HBT; end
        2: begin
          if (h) starve_at = cyc + HBT;
          if (!h && cyc == starve_at) begin m_state = 3; m_starv = 1'b1; end
          else if (cyc == kick_at) fire = 1'b1;
        end
        default: if (h) begin
          m_state = 2; m_starv = 1'b0; kick_at = cyc + KP; starve_at = cyc + HBT;
        end
      endcase
    end
    if (fire) begin m_wdi = ~m_wdi; m_cnt++; kick_at = cyc + KP; end
  endtask

  // Drive inputs at the falling edge, clock once, land on the next falling edge.
  task automatic step(input logic e, input logic h);
    en = e; hb = h;
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(e, h); else model_reset();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    cyc = 0;
    model_reset();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if ({state, wdi, wdi_oe, starving, kick_cnt, state4, wdi4, wdi_oe4, starving4, kick_cnt4} !== '0) begin
        n_err++;
        $display("FAIL reset_hold i=%0d got st=%0d wdi=%0b oe=%0b stv=%0b cnt=%0d cnt4=%0d exp all zero",
                 i, state, wdi, wdi_oe, starving, kick_cnt, kick_cnt4);
      end
    end
  endtask

  task automatic test_startup();
    logic ew;
    do_reset();
    step(1'b1, 1'b0);
    n_cmp++;
    if ({state, wdi_oe, wdi} !== {2'd1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL startup_holdoff_entry got st=%0d oe=%0b wdi=%0b exp st=1 oe=1 wdi=0", state, wdi_oe, wdi);
    end
    for (int c = 2; c <= 20; c++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if ({state, wdi} !== {2'd1, 1'b0}) begin
        n_err++;
        $display("FAIL startup_holdoff c=%0d got st=%0d wdi=%0b exp st=1 wdi=0", c, state, wdi);
      end
    end
    for (int c = 21; c <= 41; c++) begin
      step(1'b1, 1'b0);
      ew = (((c - 21) / 10) % 2 == 0) ? 1'b1 : 1'b0;
      n_cmp++;
      if ({state, wdi, kick_cnt} !== {2'd2, ew, 16'((c - 21) / 10 + 1)}) begin
        n_err++;
        $display("FAIL startup_toggle c=%0d got st=%0d wdi=%0b cnt=%0d exp st=2 wdi=%0b cnt=%0d",
                 c, state, wdi, kick_cnt, ew, (c - 21) / 10 + 1);
      end
    end
  endtask

  task automatic test_heartbeat();
    logic ew;
    do_reset();
    for (int c = 1; c <= 21; c++) step(1'b1, 1'b0);
    for (int k = 1; k <= 1000; k++) begin
      step(1'b1, (k % 30 == 0));
      ew = ((k / 10) % 2 == 0) ? 1'b1 : 1'b0;
      n_cmp++;
      if ({state, starving, wdi} !== {2'd2, 1'b0, ew}) begin
        n_err++;
        $display("FAIL heartbeat_run k=%0d got st=%0d stv=%0b wdi=%0b exp st=2 stv=0 wdi=%0b",
                 k, state, starving, wdi, ew);
      end
    end
    n_cmp++;
    if (kick_cnt !== 16'd101 || kick_cnt4 !== 4'd15) begin
      n_err++;
      $display("FAIL heartbeat_count got cnt=%0d cnt4=%0d exp cnt=101 cnt4=15", kick_cnt, kick_cnt4);
    end
  endtask

  task automatic test_starve_recover();
    int   t;
    int   cnt0;
    logic w;
    t = cyc + 1;
    step(1'b1, 1'b1);
    for (int c = t + 1; c <= t + 49; c++) step(1'b1, 1'b0);
    n_cmp++;
    if ({state, starving} !== {2'd2, 1'b0}) begin
      n_err++;
      $display("FAIL starve_not_yet got st=%0d stv=%0b exp st=2 stv=0", state, starving);
    end
    step(1'b1, 1'b0);
    n_cmp++;
    if ({state, starving, wdi_oe} !== {2'd3, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL starve_entry got st=%0d stv=%0b oe=%0b exp st=3 stv=1 oe=1", state, starving, wdi_oe);
    end
    w = m_wdi;
    cnt0 = m_cnt;
    for (int c = t + 51; c <= t + 79; c++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if ({state, wdi, kick_cnt} !== {2'd3, w, 16'(cnt0)}) begin
        n_err++;
        $display("FAIL starve_frozen c=%0d got st=%0d wdi=%0b cnt=%0d exp st=3 wdi=%0b cnt=%0d",
                 c - t, state, wdi, kick_cnt, w, cnt0);
      end
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if ({state, starving} !== {2'd2, 1'b0}) begin
      n_err++;
      $display("FAIL starve_recover got st=%0d stv=%0b exp st=2 stv=0", state, starving);
    end
    for (int c = t + 81; c <= t + 89; c++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (wdi !== w) begin
        n_err++;
        $display("FAIL recover_wait c=%0d got wdi=%0b exp wdi=%0b", c - t, wdi, w);
      end
    end
    step(1'b1, 1'b0);
    n_cmp++;
    if ({wdi, kick_cnt} !== {~w, 16'(cnt0 + 1)}) begin
      n_err++;
      $display("FAIL recover_toggle got wdi=%0b cnt=%0d exp wdi=%0b cnt=%0d", wdi, kick_cnt, ~w, cnt0 + 1);
    end
  endtask

  task automatic test_en_drop();
    int g;
    int e0;
    int cnt0;
    g = 0;
    while (kick_at != cyc + 1 && g < 30) begin step(1'b1, 1'b0); g++; end
    n_cmp++;
    if (g >= 30) begin
      n_err++;
      $display("FAIL en_drop_align got wait=%0d exp wait<30", g);
    end
    cnt0 = m_cnt;
    step(1'b0, 1'b0);
    n_cmp++;
    if ({state, wdi_oe, wdi, starving, kick_cnt} !== {2'd0, 1'b0, 1'b0, 1'b0, 16'(cnt0)}) begin
      n_err++;
      $display("FAIL en_drop got st=%0d oe=%0b wdi=%0b stv=%0b cnt=%0d exp st=0 oe=0 wdi=0 stv=0 cnt=%0d",
               state, wdi_oe, wdi, starving, kick_cnt, cnt0);
    end
    step(1'b1, 1'b0);
    e0 = cyc;
    n_cmp++;
    if ({state, wdi_oe, wdi} !== {2'd1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL en_reentry got st=%0d oe=%0b wdi=%0b exp st=1 oe=1 wdi=0", state, wdi_oe, wdi);
    end
    for (int c = e0 + 1; c <= e0 + 19; c++) begin
      step(1'b1, (c == e0 + 5));
      n_cmp++;
      if ({state, wdi} !== {2'd1, 1'b0}) begin
        n_err++;
        $display("FAIL en_holdoff c=%0d got st=%0d wdi=%0b exp st=1 wdi=0", c - e0, state, wdi);
      end
    end
    step(1'b1, 1'b0);
    n_cmp++;
    if ({state, wdi, kick_cnt} !== {2'd2, 1'b1, 16'(cnt0 + 1)}) begin
      n_err++;
      $display("FAIL en_first_toggle got st=%0d wdi=%0b cnt=%0d exp st=2 wdi=1 cnt=%0d",
               state, wdi, kick_cnt, cnt0 + 1);
    end
  endtask

  task automatic test_hb_at_expiry();
    int g;
    int h0;
    g = 0;
    while (starve_at != cyc + 1 && g < 60) begin step(1'b1, 1'b0); g++; end
    n_cmp++;
    if (g >= 60) begin
      n_err++;
      $display("FAIL hb_expiry_align got wait=%0d exp wait<60", g);
    end
    step(1'b1, 1'b1);
    h0 = cyc;
    n_cmp++;
    if ({state, starving} !== {2'd2, 1'b0}) begin
      n_err++;
      $display("FAIL hb_at_expiry got st=%0d stv=%0b exp st=2 stv=0", state, starving);
    end
    for (int c = h0 + 1; c <= h0 + 49; c++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (state !== 2'd2) begin
        n_err++;
        $display("FAIL hb_restart_run c=%0d got st=%0d exp st=2", c - h0, state);
      end
    end
    step(1'b1, 1'b0);
    n_cmp++;
    if ({state, starving} !== {2'd3, 1'b1}) begin
      n_err++;
      $display("FAIL hb_restart_starve got st=%0d stv=%0b exp st=3 stv=1", state, starving);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b1);
    for (int i = 0; i < 35; i++) step(1'b1, (i % 20 == 0));
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({state, wdi, wdi_oe, starving, kick_cnt, state4, kick_cnt4} !== '0) begin
      n_err++;
      $display("FAIL async_reset_now got st=%0d wdi=%0b oe=%0b stv=%0b cnt=%0d cnt4=%0d exp all zero",
               state, wdi, wdi_oe, starving, kick_cnt, kick_cnt4);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if ({state, wdi, wdi_oe, starving, kick_cnt} !== '0) begin
        n_err++;
        $display("FAIL async_reset_hold i=%0d got st=%0d oe=%0b cnt=%0d exp all zero", i, state, wdi_oe, kick_cnt);
      end
    end
    rst_n = 1'b1;
    cyc = 0;
    model_reset();
    step(1'b1, 1'b0);
    n_cmp++;
    if ({state, wdi_oe} !== {2'd1, 1'b1}) begin
      n_err++;
      $display("FAIL post_reset_holdoff got st=%0d oe=%0b exp st=1 oe=1", state, wdi_oe);
    end
    for (int c = 2; c <= 21; c++) step(1'b1, 1'b0);
    n_cmp++;
    if ({state, wdi, kick_cnt, kick_cnt4} !== {2'd2, 1'b1, 16'd1, 4'd1}) begin
      n_err++;
      $display("FAIL post_reset_toggle got st=%0d wdi=%0b cnt=%0d cnt4=%0d exp st=2 wdi=1 cnt=1 cnt4=1",
               state, wdi, kick_cnt, kick_cnt4);
    end
  endtask

  task automatic test_random();
    logic [20:0] exp_v, got_v;
    logic [8:0]  exp4, got4;
    int off;
    logic e, h;
    off = 0;
    for (int i = 0; i < 4000; i++) begin
      if (off == 0 && $urandom_range(149) == 0) off = $urandom_range(3, 1);
      e = (off > 0) ? 1'b0 : 1'b1;
      if (off > 0) off--;
      h = (((i / 1000) % 2) == 0) ? ($urandom_range(19) == 0) : ($urandom_range(69) == 0);
      rst_n = ($urandom_range(399) != 0);
      step(e, h);
      exp_v = {2'(m_state), m_wdi, m_oe, m_starv, 16'(m_cnt)};
      got_v = {state, wdi, wdi_oe, starving, kick_cnt};
      exp4  = {2'(m_state), m_wdi, m_oe, m_starv, 4'((m_cnt > 15) ? 15 : m_cnt)};
      got4  = {state4, wdi4, wdi_oe4, starving4, kick_cnt4};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL random_w16 i=%0d got st=%0d wdi=%0b oe=%0b stv=%0b cnt=%0d exp st=%0d wdi=%0b oe=%0b stv=%0b cnt=%0d",
                 i, state, wdi, wdi_oe, starving, kick_cnt, m_state, m_wdi, m_oe, m_starv, m_cnt);
      end
      n_cmp++;
      if (got4 !== exp4) begin
        n_err++;
        $display("FAIL random_w4 i=%0d got st=%0d wdi=%0b oe=%0b stv=%0b cnt=%0d exp vec=%h got vec=%h",
                 i, state4, wdi4, wdi_oe4, starving4, kick_cnt4, exp4, got4);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got time=%0t exp finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_startup();
    test_heartbeat();
    test_starve_recover();
    test_en_drop();
    test_hb_at_expiry();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
